// File: rtl/stalling_pipe_front.sv
// IF/ID/EX front end: one fetch per cycle, hazard stall with bubble insertion,
// downstream backpressure, redirect flush, and a saturating stall-cycle counter.
module stalling_pipe_front #(
   parameter int XLEN     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0,
   parameter int PC_STEP  = 4,
   parameter int HAZ_MODE = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [XLEN-1:0]  imem_rdata,
   input  logic             imem_valid,
   input  logic             ex_ready,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_instr,
   output logic [4:0]       ex_dest,
   output logic             ex_is_load,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LOAD  = 6'h23;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] instr;
      logic [4:0]      dest;
      logic            is_load;
   } ex_reg_t;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             id_valid_q, id_valid_d;
   logic [XLEN-1:0]  id_instr_q, id_instr_d;
   ex_reg_t          ex_q, ex_d;
   logic [CNT_W-1:0] cnt_q;

   // ID decode
   logic [5:0] id_op;
   logic [4:0] id_rs, id_rt, id_rd, id_dest;
   logic       id_load, hazard;

   always_comb begin
      id_op   = id_instr_q[31:26];
      id_rs   = id_instr_q[25:21];
      id_rt   = id_instr_q[20:16];
      id_rd   = id_instr_q[15:11];
      id_load = (id_op == OP_LOAD);
      id_dest = 5'd0;
      if (id_op == OP_RTYPE) id_dest = id_rd;
      else if (id_load)      id_dest = id_rt;
   end

   always_comb begin
      hazard = id_valid_q && ex_q.valid && (ex_q.dest != 5'd0) &&
               ((id_rs == ex_q.dest) || (id_rt == ex_q.dest));
      if (HAZ_MODE == 1) hazard = hazard && ex_q.is_load;
   end

   // Backpressure and redirect both suppress the stall so it is never counted twice.
   assign stall = hazard && ex_ready && !redirect_valid;

   always_comb begin
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      ex_d       = ex_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc;
         id_valid_d = 1'b0;
         id_instr_d = '0;
         if (ex_ready) ex_d = '0;
      end else if (!ex_ready) begin
         // frozen
      end else if (hazard) begin
         ex_d = '0;
      end else begin
         ex_d.valid   = id_valid_q;
         ex_d.instr   = id_valid_q ? id_instr_q : '0;
         ex_d.dest    = id_valid_q ? id_dest : 5'd0;
         ex_d.is_load = id_valid_q && id_load;
         if (imem_valid) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            pc_d       = pc_q + XLEN'(PC_STEP);
         end else begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= PC_RESET;
         id_valid_q <= 1'b0;
         id_instr_q <= '0;
         ex_q       <= '0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         ex_q       <= ex_d;
         if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign imem_addr  = pc_q;
   assign ex_valid   = ex_q.valid;
   assign ex_instr   = ex_q.instr;
   assign ex_dest    = ex_q.dest;
   assign ex_is_load = ex_q.is_load;
   assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_stalling_pipe_front.sv
// Directed bench for stalling_pipe_front: three instances (load-use mode,
// no-forwarding mode, 2-bit counter) share stimulus and one program memory.
module tb_stalling_pipe_front;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, imem_valid, ex_ready, redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] prog [128];

   logic [31:0] a1, r1, i1; logic v1, l1, s1; logic [4:0] d1; logic [15:0] c1;
   logic [31:0] a0, r0, i0; logic v0, l0, s0; logic [4:0] d0; logic [15:0] c0;
   logic [31:0] a2, r2, i2; logic v2, l2, s2; logic [4:0] d2; logic [1:0]  c2;

   assign r1 = prog[a1[8:2]];
   assign r0 = prog[a0[8:2]];
   assign r2 = prog[a2[8:2]];

   stalling_pipe_front #(.HAZ_MODE(1)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(a1), .imem_rdata(r1), .imem_valid(imem_valid),
      .ex_ready(ex_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ex_valid(v1), .ex_instr(i1), .ex_dest(d1), .ex_is_load(l1), .stall(s1), .stall_cnt(c1));

   stalling_pipe_front #(.HAZ_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .imem_addr(a0), .imem_rdata(r0), .imem_valid(imem_valid),
      .ex_ready(ex_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ex_valid(v0), .ex_instr(i0), .ex_dest(d0), .ex_is_load(l0), .stall(s0), .stall_cnt(c0));

   stalling_pipe_front #(.HAZ_MODE(1), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .imem_addr(a2), .imem_rdata(r2), .imem_valid(imem_valid),
      .ex_ready(ex_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ex_valid(v2), .ex_instr(i2), .ex_dest(d2), .ex_is_load(l2), .stall(s2), .stall_cnt(c2));

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] LW5  = 32'h8C050000; // lw  $5,0($0)
   localparam logic [31:0] ADD6 = 32'h00A73020; // add $6,$5,$7
   localparam logic [31:0] ADD5 = 32'h00222820; // add $5,$1,$2
   localparam logic [31:0] SUB8 = 32'h00A14022; // sub $8,$5,$1
   localparam logic [31:0] ADD0 = 32'h00220020; // add $0,$1,$2
   localparam logic [31:0] USE0 = 32'h00014022; // sub $8,$0,$1
   localparam logic [31:0] LW0  = 32'h8C000000; // lw  $0,0($0)
   localparam logic [31:0] IM1  = 32'h20010001; // addi, no register dest
   localparam logic [31:0] IM2  = 32'h20020002;
   localparam logic [31:0] IM3  = 32'h20030003;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_prog();
      for (int k = 0; k < 128; k++) prog[k] = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; imem_valid = 1'b1; ex_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_prog();
      do_reset();
      total++; if (a1 !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", a1); end
      total++; if (v1 !== 1'b0 || i1 !== 32'h0 || d1 !== 5'd0 || l1 !== 1'b0) begin
         bad++; $display("FAIL reset_ex got v=%b i=%h d=%0d l=%b exp all 0", v1, i1, d1, l1); end
      total++; if (c1 !== 16'h0 || s1 !== 1'b0) begin
         bad++; $display("FAIL reset_cnt got cnt=%0d stall=%b exp 0/0", c1, s1); end
   endtask

   task automatic test_basic();
      clear_prog(); prog[0] = IM1; prog[1] = IM2; prog[2] = IM3; prog[3] = IM1;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         step();
         total++; if (a1 !== 32'(4*k)) begin bad++; $display("FAIL basic_pc%0d got=%h exp=%h", k, a1, 32'(4*k)); end
         total++; if (v1 !== (k >= 2)) begin bad++; $display("FAIL basic_vld%0d got=%b exp=%b", k, v1, k >= 2); end
      end
      total++; if (i1 !== IM2) begin bad++; $display("FAIL basic_instr got=%h exp=%h", i1, IM2); end
      imem_valid = 1'b0;
      step();
      total++; if (a1 !== 32'd12 || i1 !== IM3) begin
         bad++; $display("FAIL basic_imemhold got pc=%h i=%h exp pc=c i=%h", a1, i1, IM3); end
      imem_valid = 1'b1;
      step();
      total++; if (v1 !== 1'b0) begin bad++; $display("FAIL basic_fetchbubble got=%b exp=0", v1); end
      total++; if (c1 !== 16'h0) begin bad++; $display("FAIL basic_cnt got=%0d exp=0", c1); end
   endtask

   task automatic test_load_use();
      clear_prog(); prog[0] = LW5; prog[1] = ADD6; prog[2] = IM1;
      do_reset();
      step(); step();
      total++; if (s1 !== 1'b1 || d1 !== 5'd5 || l1 !== 1'b1) begin
         bad++; $display("FAIL lu_stall got s=%b d=%0d l=%b exp 1/5/1", s1, d1, l1); end
      step();
      total++; if (v1 !== 1'b0 || a1 !== 32'd8 || c1 !== 16'd1 || s1 !== 1'b0) begin
         bad++; $display("FAIL lu_bubble got v=%b pc=%h cnt=%0d s=%b exp 0/8/1/0", v1, a1, c1, s1); end
      step();
      total++; if (i1 !== ADD6 || v1 !== 1'b1 || d1 !== 5'd6 || a1 !== 32'd12) begin
         bad++; $display("FAIL lu_use got i=%h v=%b d=%0d pc=%h exp %h/1/6/c", i1, v1, d1, a1, ADD6); end
   endtask

   task automatic test_modes();
      clear_prog(); prog[0] = ADD5; prog[1] = SUB8; prog[2] = IM1;
      do_reset();
      step(); step();
      total++; if (s1 !== 1'b0 || s0 !== 1'b1) begin
         bad++; $display("FAIL mode_stall got m1=%b m0=%b exp 0/1", s1, s0); end
      step();
      total++; if (i1 !== SUB8 || v0 !== 1'b0) begin
         bad++; $display("FAIL mode_ex got m1i=%h m0v=%b exp %h/0", i1, v0, SUB8); end
      step();
      total++; if (i0 !== SUB8 || c0 !== 16'd1 || c1 !== 16'd0) begin
         bad++; $display("FAIL mode_late got m0i=%h c0=%0d c1=%0d exp %h/1/0", i0, c0, c1, SUB8); end
      clear_prog(); prog[0] = ADD0; prog[1] = USE0; prog[2] = LW0; prog[3] = USE0;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         step();
         total++; if (s1 !== 1'b0 || s0 !== 1'b0) begin
            bad++; $display("FAIL reg0_stall%0d got m1=%b m0=%b exp 0/0", k, s1, s0); end
      end
      total++; if (c1 !== 16'd0 || c0 !== 16'd0 || a0 !== 32'd24) begin
         bad++; $display("FAIL reg0_cnt got c1=%0d c0=%0d pc0=%h exp 0/0/18", c1, c0, a0); end
   endtask

   task automatic test_backpressure();
      clear_prog(); prog[0] = LW5; prog[1] = ADD6; prog[2] = IM1;
      do_reset();
      step(); step();
      ex_ready = 1'b0; #1;
      total++; if (s1 !== 1'b0) begin bad++; $display("FAIL bp_nostall got=%b exp=0", s1); end
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (i1 !== LW5 || a1 !== 32'd8 || s1 !== 1'b0 || v1 !== 1'b1) begin
            bad++; $display("FAIL bp_freeze%0d got i=%h pc=%h s=%b v=%b exp %h/8/0/1", k, i1, a1, s1, v1, LW5); end
      end
      ex_ready = 1'b1; #1;
      total++; if (s1 !== 1'b1 || c1 !== 16'd0) begin
         bad++; $display("FAIL bp_resume got s=%b cnt=%0d exp 1/0", s1, c1); end
      step();
      total++; if (v1 !== 1'b0 || c1 !== 16'd1) begin
         bad++; $display("FAIL bp_bubble got v=%b cnt=%0d exp 0/1", v1, c1); end
      step();
      total++; if (i1 !== ADD6) begin bad++; $display("FAIL bp_use got=%h exp=%h", i1, ADD6); end
   endtask

   task automatic test_redirect();
      clear_prog(); prog[0] = LW5; prog[1] = ADD6; prog[64] = IM2; prog[65] = IM3; prog[127] = IM1;
      do_reset();
      step(); step();
      redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      total++; if (s1 !== 1'b0) begin bad++; $display("FAIL rd_nostall got=%b exp=0", s1); end
      step();
      redirect_valid = 1'b0;
      total++; if (a1 !== 32'h100 || v1 !== 1'b0 || c1 !== 16'd0) begin
         bad++; $display("FAIL rd_flush got pc=%h v=%b cnt=%0d exp 100/0/0", a1, v1, c1); end
      step();
      total++; if (v1 !== 1'b0 || a1 !== 32'h104) begin
         bad++; $display("FAIL rd_idflushed got v=%b pc=%h exp 0/104", v1, a1); end
      step();
      total++; if (i1 !== IM2 || v1 !== 1'b1 || c1 !== 16'd0) begin
         bad++; $display("FAIL rd_target got i=%h v=%b cnt=%0d exp %h/1/0", i1, v1, c1, IM2); end
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      step();
      total++; if (a1 !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=0", a1); end
   endtask

   task automatic test_saturate_reset();
      clear_prog();
      for (int k = 0; k < 6; k++) begin prog[2*k] = LW5; prog[2*k+1] = ADD6; end
      do_reset();
      for (int k = 0; k < 15; k++) step();
      total++; if (c2 !== 2'd3 || c1 !== 16'd5) begin
         bad++; $display("FAIL sat_cnt got c2=%0d c1=%0d exp 3/5", c2, c1); end
      step(); step();
      total++; if (s2 !== 1'b1) begin bad++; $display("FAIL sat_midstall got=%b exp=1", s2); end
      rst_n = 1'b0; #1;
      total++; if (a2 !== 32'h0 || v2 !== 1'b0 || i2 !== 32'h0 || d2 !== 5'd0 || l2 !== 1'b0 ||
                   s2 !== 1'b0 || c2 !== 2'd0) begin
         bad++; $display("FAIL async_reset got pc=%h v=%b i=%h d=%0d l=%b s=%b c=%0d exp all 0",
                         a2, v2, i2, d2, l2, s2, c2); end
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_load_use();
      test_modes();
      test_backpressure();
      test_redirect();
      test_saturate_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
